// File: rtl/fv_bank_streamer_if.sv
// Request, SRAM-read and Bank2RS signals of the feature-vector bank streamer.
// The slave modport is the streamer; the master is the environment around it.
interface fv_bank_streamer_if #(
  parameter int FV_SIZE     = 16,
  parameter int MAX_FV_NUM  = 16,
  parameter int MAX_NODE_ID = 256,
  parameter int BANK_DEPTH  = 1024
);
  localparam int NW = $clog2(MAX_NODE_ID);
  localparam int AW = $clog2(BANK_DEPTH);
  localparam int LW = $clog2(MAX_FV_NUM / 2) + 1;

  logic                   req_valid;
  logic                   req_ready;
  logic [NW-1:0]          req_node_id;
  logic [AW-1:0]          req_base_addr;
  logic [LW-1:0]          req_num_lines;
  logic                   RS_available;
  logic                   mem_rd_en;
  logic [AW-1:0]          mem_rd_addr;
  logic [2*FV_SIZE-1:0]   mem_rd_data;
  logic                   Bank2RS_sos;
  logic                   Bank2RS_eos;
  logic [2*FV_SIZE-1:0]   Bank2RS_FV_data;
  logic [NW-1:0]          Bank2RS_Node_id;
  logic                   busy;

  modport slave (
    input  req_valid, req_node_id, req_base_addr, req_num_lines, RS_available, mem_rd_data,
    output req_ready, mem_rd_en, mem_rd_addr, Bank2RS_sos, Bank2RS_eos, Bank2RS_FV_data,
           Bank2RS_Node_id, busy
  );

  modport master (
    output req_valid, req_node_id, req_base_addr, req_num_lines, RS_available, mem_rd_data,
    input  req_ready, mem_rd_en, mem_rd_addr, Bank2RS_sos, Bank2RS_eos, Bank2RS_FV_data,
           Bank2RS_Node_id, busy
  );
endinterface

// File: rtl/fv_bank_streamer.sv
// Reads one node's feature vector from an SRAM bank and streams it to Vertex RS
// as a bubble-free Bank2RS packet, two elements per beat, gated on RS_available.
module fv_bank_streamer #(
  parameter int FV_SIZE     = 16,
  parameter int MAX_FV_NUM  = 16,
  parameter int MAX_NODE_ID = 256,
  parameter int BANK_DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  fv_bank_streamer_if.slave bus
);
  localparam int NW = $clog2(MAX_NODE_ID);
  localparam int AW = $clog2(BANK_DEPTH);
  localparam int LW = $clog2(MAX_FV_NUM / 2) + 1;
  localparam logic [LW-1:0] MAX_LINES = LW'(MAX_FV_NUM / 2);
  localparam logic [LW-1:0] MIN_LINES = LW'(2);

  typedef enum logic [1:0] {IDLE, WAIT_RS, STREAM} state_e;

  state_e        state_q, state_d;
  logic [NW-1:0] node_q, node_d;
  logic [AW-1:0] base_q, base_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] k_q, k_d;
  logic          sos_q, sos_d;
  logic          eos_q, eos_d;
  logic          beat_q, beat_d;
  logic [NW-1:0] beat_node_q, beat_node_d;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    node_d  = node_q;
    base_d  = base_q;
    len_d   = len_q;
    k_d     = k_q;
    rd_en   = 1'b0;
    rd_addr = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          node_d = bus.req_node_id;
          base_d = bus.req_base_addr;
          if (bus.req_num_lines < MIN_LINES)      len_d = MIN_LINES;
          else if (bus.req_num_lines > MAX_LINES) len_d = MAX_LINES;
          else                                    len_d = bus.req_num_lines;
          k_d     = '0;
          state_d = WAIT_RS;
        end
      end
      // Safe to read straight from RS_available: sos is registered, so no comb loop through RS.
      WAIT_RS: begin
        if (bus.RS_available) begin
          rd_en   = 1'b1;
          rd_addr = base_q;
          k_d     = LW'(1);
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (k_q < len_q) begin
          rd_en   = 1'b1;
          rd_addr = base_q + AW'(k_q);
          k_d     = k_q + LW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Beat flags describe the read issued this cycle; they appear with its data next cycle.
    beat_d      = rd_en;
    sos_d       = rd_en && (k_q == '0);
    eos_d       = rd_en && (k_q == len_q - LW'(1));
    beat_node_d = rd_en ? node_q : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      node_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      k_q         <= '0;
      sos_q       <= 1'b0;
      eos_q       <= 1'b0;
      beat_q      <= 1'b0;
      beat_node_q <= '0;
    end else begin
      state_q     <= state_d;
      node_q      <= node_d;
      base_q      <= base_d;
      len_q       <= len_d;
      k_q         <= k_d;
      sos_q       <= sos_d;
      eos_q       <= eos_d;
      beat_q      <= beat_d;
      beat_node_q <= beat_node_d;
    end
  end

  assign bus.req_ready       = (state_q == IDLE);
  assign bus.mem_rd_en       = rd_en;
  assign bus.mem_rd_addr     = rd_addr;
  assign bus.Bank2RS_sos     = sos_q;
  assign bus.Bank2RS_eos     = eos_q;
  assign bus.Bank2RS_Node_id = beat_node_q;
  assign bus.Bank2RS_FV_data = beat_q ? bus.mem_rd_data : '0;
  assign bus.busy            = (state_q != IDLE) | beat_q;
endmodule

// File: tb/tb_fv_bank_streamer.sv
// Randomized self-checking bench for fv_bank_streamer against a cycle-table
// reference model derived from the packet timing rules.
module tb_fv_bank_streamer;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        en;
    logic [9:0]  addr;
    logic        sos;
    logic        eos;
    logic [7:0]  node;
    logic [31:0] data;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] mem [DEPTH];
  logic [31:0] mem_q;
  int n_checks = 0;
  int n_pass   = 0;

  fv_bank_streamer_if bus ();

  fv_bank_streamer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency.
  always @(posedge clk) if (bus.mem_rd_en) mem_q <= mem[bus.mem_rd_addr];
  assign bus.mem_rd_data = mem_q;

  function automatic obs_t sample();
    obs_t o;
    o.ready = bus.req_ready;
    o.busy  = bus.busy;
    o.en    = bus.mem_rd_en;
    o.addr  = bus.mem_rd_en ? bus.mem_rd_addr : 10'd0;
    o.sos   = bus.Bank2RS_sos;
    o.eos   = bus.Bank2RS_eos;
    o.node  = bus.Bank2RS_Node_id;
    o.data  = bus.Bank2RS_FV_data;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o       = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  // One request: accept cycle 0, RS held low for rs_delay cycles, then the packet.
  // Reads at cycles r..r+L-1, beats at r+1..r+L where r = rs_delay+1.
  task automatic run_packet(input logic [7:0] node, input logic [9:0] base,
                            input logic [3:0] n, input int rs_delay, input string name);
    int   len;
    int   r;
    obs_t exp;
    obs_t got;
    len = (n < 2) ? 2 : ((n > 8) ? 8 : int'(n));
    r   = rs_delay + 1;

    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.req_node_id   = node;
    bus.req_base_addr = base;
    bus.req_num_lines = n;
    bus.RS_available  = 1'($urandom_range(0, 1));
    #1;
    got = sample();
    exp = idle_obs();
    n_checks++;
    if (got !== exp) $display("FAIL %s accept: got %h expected %h", name, got, exp);
    else n_pass++;

    for (int j = 1; j <= r + len; j++) begin
      @(negedge clk);
      bus.req_valid     = 1'b0;
      bus.req_node_id   = 8'($urandom);
      bus.req_base_addr = 10'($urandom);
      bus.req_num_lines = 4'($urandom);
      if (j < r)       bus.RS_available = 1'b0;
      else if (j == r) bus.RS_available = 1'b1;
      else             bus.RS_available = 1'($urandom_range(0, 1));
      #1;
      exp       = '0;
      exp.busy  = 1'b1;
      exp.en    = (j >= r) && (j < r + len);
      exp.addr  = exp.en ? 10'((int'(base) + (j - r)) % DEPTH) : 10'd0;
      if (j > r) begin
        exp.sos  = (j - r - 1 == 0);
        exp.eos  = (j - r - 1 == len - 1);
        exp.node = node;
        exp.data = mem[(int'(base) + (j - r - 1)) % DEPTH];
      end
      got = sample();
      n_checks++;
      if (got !== exp) $display("FAIL %s cycle %0d: got %h expected %h", name, j, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset(input string name);
    obs_t got;
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid    = 1'b0;
    bus.RS_available = 1'b1;
    @(negedge clk);
    #1;
    got = sample();
    n_checks++;
    if (got !== idle_obs()) $display("FAIL %s during: got %h expected %h", name, got, idle_obs());
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    got = sample();
    n_checks++;
    if (got !== idle_obs()) $display("FAIL %s after: got %h expected %h", name, got, idle_obs());
    else n_pass++;
  endtask

  task automatic test_idle(input string name);
    obs_t got;
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.RS_available = 1'($urandom_range(0, 1));
    #1;
    got = sample();
    n_checks++;
    if (got !== idle_obs()) $display("FAIL %s: got %h expected %h", name, got, idle_obs());
    else n_pass++;
  endtask

  task automatic test_basic();
    mem[10'h010] = 32'hA0A1_A0A0;
    mem[10'h011] = 32'hB0B1_B0B0;
    mem[10'h012] = 32'hC0C1_C0C0;
    mem[10'h013] = 32'hD0D1_D0D0;
    run_packet(8'd5, 10'h010, 4'd4, 0, "basic");
    test_idle("basic_ready");
  endtask

  task automatic test_gating();
    run_packet(8'd9, 10'h010, 4'd4, 10, "gating");
    test_idle("gating_ready");
  endtask

  task automatic test_wrap();
    run_packet(8'd33, 10'd1022, 4'd4, 0, "wrap");
    run_packet(8'd34, 10'd1023, 4'd8, 1, "wrap8");
    test_idle("wrap_ready");
  endtask

  task automatic test_clamp();
    run_packet(8'd1, 10'd100, 4'd1, 0, "clamp_1");
    run_packet(8'd2, 10'd200, 4'd0, 0, "clamp_0");
    run_packet(8'd3, 10'd300, 4'd2, 0, "lines_2");
    run_packet(8'd4, 10'd400, 4'd8, 0, "lines_8");
    run_packet(8'd6, 10'd500, 4'd12, 0, "clamp_12");
    run_packet(8'd7, 10'd600, 4'd15, 2, "clamp_15");
    test_idle("clamp_ready");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      logic [9:0] base;
      base = ($urandom_range(0, 3) == 0) ? 10'(1018 + $urandom_range(0, 5)) : 10'($urandom);
      run_packet(8'($urandom), base, 4'($urandom), int'($urandom_range(0, 3)), "random");
    end
    test_idle("random_ready");
  endtask

  task automatic test_mid_reset();
    obs_t got;
    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.req_node_id   = 8'd77;
    bus.req_base_addr = 10'd40;
    bus.req_num_lines = 4'd4;
    bus.RS_available  = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    #1;
    n_checks++;
    if (bus.Bank2RS_FV_data !== mem[41] || bus.Bank2RS_eos !== 1'b0)
      $display("FAIL midrst_beat2: got data %h eos %b expected data %h eos 0",
               bus.Bank2RS_FV_data, bus.Bank2RS_eos, mem[41]);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      got = sample();
      n_checks++;
      if (got !== idle_obs()) $display("FAIL midrst_idle cycle %0d: got %h expected %h", j, got, idle_obs());
      else n_pass++;
    end
    run_packet(8'd78, 10'd50, 4'd4, 0, "after_midrst");
    test_idle("after_midrst_ready");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    reset             = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_node_id   = '0;
    bus.req_base_addr = '0;
    bus.req_num_lines = '0;
    bus.RS_available  = 1'b0;
    test_reset("reset_init");
    test_idle("idle");
    test_reset("reset_idle");
    test_basic();
    test_gating();
    test_wrap();
    test_clamp();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
